// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// No logic of its own; functions are pure combinational helpers.
// No flow control here; the importing modules handle backpressure.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_e;

  // Byte strobes of an access as if it started at lane 0.
  function automatic logic [3:0] byte_strobe(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: byte_strobe = 4'b0001;
      F3_H, F3_HU: byte_strobe = 4'b0011;
      default:     byte_strobe = 4'b1111;
    endcase
  endfunction

  // True when the access would straddle its natural alignment.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] ofs);
    case (f3)
      F3_H, F3_HU: is_misaligned = ofs[0];
      F3_W:        is_misaligned = (ofs != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  // Unsigned variants only make sense for loads; unused encodings are always illegal.
  function automatic logic is_illegal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: is_illegal = 1'b0;
      F3_BU, F3_HU:     is_illegal = we;
      default:          is_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane placement plus load byte/half extraction and sign/zero extension.
// Purely combinational, zero latency.
// No flow control; the caller decides when the outputs are used.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  ofs,
  input  logic [31:0] wdata,
  output logic [31:0] lane_wd,
  output logic [7:0]  strb,
  input  logic [63:0] rword,
  output logic [31:0] ext
);

  logic [63:0] wdata2;
  logic [5:0]  rbase;
  logic [5:0]  lbase;
  logic [31:0] sel;

  // Store side: replicate narrow data into every lane; a misaligned access uses a
  // byte rotation so the same word serves both halves of a split access.
  always_comb begin
    wdata2  = {wdata, wdata};
    rbase   = 6'd32 - {1'b0, ofs, 3'b000};
    lane_wd = wdata2[rbase +: 32];
    if (funct3 == F3_B)
      lane_wd = {4{wdata[7:0]}};
    else if (funct3 == F3_H && !ofs[0])
      lane_wd = {2{wdata[15:0]}};
    strb = {4'b0000, byte_strobe(funct3)} << ofs;
  end

  // Load side: rword is {next word, this word}; shift down by the byte offset, then extend.
  always_comb begin
    lbase = {1'b0, ofs, 3'b000};
    sel   = rword[lbase +: 32];
    case (funct3)
      F3_B:    ext = {{24{sel[7]}}, sel[7:0]};
      F3_H:    ext = {{16{sel[15]}}, sel[15:0]};
      F3_BU:   ext = {24'h0, sel[7:0]};
      F3_HU:   ext = {16'h0, sel[15:0]};
      default: ext = sel;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, word-aligned access, lane strobes, load extension.
// Latency: aligned T+2, errors T+1, split misaligned (LSU_MISALIGN_SPLIT_EN) T+3.
// Backpressure: req_ready high only in IDLE; requests while busy are dropped, not queued.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [3:0]            mem_wr,
  input  logic [DATA_W-1:0]     mem_rd
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [2:0]          f3_q;
  logic [1:0]          ofs_q;
  logic                we_q;
  logic                err_q;
  logic                split_q;
  logic [DATA_W-1:0]   rd_lo_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                acc_mis, acc_illegal, acc_err, acc_split;
  logic [2:0]          a_f3;
  logic [1:0]          a_ofs;
  logic [2*DATA_W-1:0] a_rword;
  logic [DATA_W-1:0]   lane_wd, ext;
  logic [7:0]          strb;

  assign acc_illegal = is_illegal(req_funct3, req_we);
  assign acc_mis     = is_misaligned(req_funct3, req_addr[1:0]);
  assign acc_err     = acc_illegal || (acc_mis && !SPLIT_EN);
  assign acc_split   = acc_mis && !acc_illegal && SPLIT_EN;

  // The aligner sees the live request while idle, the captured request afterwards.
  assign a_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
  assign a_ofs   = (state_q == IDLE) ? req_addr[1:0] : ofs_q;
  assign a_rword = split_q ? {mem_rd, rd_lo_q} : {{DATA_W{1'b0}}, mem_rd};

  lsu_align u_align (
    .funct3  (a_f3),
    .ofs     (a_ofs),
    .wdata   (req_wdata),
    .lane_wd (lane_wd),
    .strb    (strb),
    .rword   (a_rword),
    .ext     (ext)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake/response outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = acc_err ? RESP : ACC1;
      end
      ACC1: state_d = split_q ? ACC2 : RESP;
      ACC2: state_d = RESP;
      RESP: begin
        state_d   = IDLE;
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!err_q) rsp_rdata = rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, memory-side drive and load-data capture at the end of the last access cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q     <= '0;
      ofs_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      split_q  <= 1'b0;
      rd_lo_q  <= '0;
      rdata_q  <= '0;
      mem_addr <= '0;
      mem_wd   <= '0;
      mem_wr   <= '0;
    end else begin
      mem_wr <= '0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            f3_q    <= req_funct3;
            ofs_q   <= req_addr[1:0];
            we_q    <= req_we;
            err_q   <= acc_err;
            split_q <= acc_split;
            if (!acc_err) begin
              mem_addr <= {req_addr[DM_ADDRESS-1:2], 2'b00};
              mem_wd   <= lane_wd;
              if (req_we) mem_wr <= strb[3:0];
            end
          end
        end
        ACC1: begin
          if (split_q) begin
            rd_lo_q  <= mem_rd;
            mem_addr <= mem_addr + DM_ADDRESS'(4);
            if (we_q) mem_wr <= strb[7:4];
          end else begin
            rdata_q <= we_q ? '0 : ext;
          end
        end
        ACC2: rdata_q <= we_q ? '0 : ext;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-wide memory model.
// Memory read data is combinational from mem_addr; writes land on the clock edge.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wd, mem_rd;
  logic [3:0]  mem_wr;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:127];

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_wr(mem_wr), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[8:2]];

  always @(posedge clk) begin
    if (mem_wr[0]) mem[mem_addr[8:2]][7:0]   <= mem_wd[7:0];
    if (mem_wr[1]) mem[mem_addr[8:2]][15:8]  <= mem_wd[15:8];
    if (mem_wr[2]) mem[mem_addr[8:2]][23:16] <= mem_wd[23:16];
    if (mem_wr[3]) mem[mem_addr[8:2]][31:24] <= mem_wd[31:24];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns 1ns into T+1.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic store(input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] wd);
    issue(1'b1, f3, addr, wd);
    step();
    step();
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [8:0] addr,
                          input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'h0);
    step();
    check({tag, "_vld"}, {31'h0, rsp_valid}, 32'h1);
    check({tag, "_data"}, rsp_rdata, exp);
    step();
  endtask

  logic [8:0] ready_pat, vld_pat;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    step();
    step();
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_err",   {31'h0, rsp_err},   32'h0);
    check("rst_mem_wr",    {28'h0, mem_wr},    32'h0);
    check("rst_mem_addr",  {23'h0, mem_addr},  32'h0);
    check("rst_mem_wd",    mem_wd,             32'h0);
    check("rst_rsp_rdata", rsp_rdata,          32'h0);
    rst_n = 1'b1;
    step();
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);

    // SW 0x010
    issue(1'b1, 3'b010, 9'h010, 32'hDEADBEEF);
    check("sw_addr",  {23'h0, mem_addr}, 32'h010);
    check("sw_wr",    {28'h0, mem_wr},   32'hF);
    check("sw_wd",    mem_wd,            32'hDEADBEEF);
    check("sw_ready", {31'h0, req_ready}, 32'h0);
    check("sw_early", {31'h0, rsp_valid}, 32'h0);
    step();
    check("sw_vld",   {31'h0, rsp_valid}, 32'h1);
    check("sw_err",   {31'h0, rsp_err},   32'h0);
    check("sw_rdata", rsp_rdata,          32'h0);
    check("sw_wr_off", {28'h0, mem_wr},   32'h0);
    step();
    check("sw_idle_ready", {31'h0, req_ready}, 32'h1);
    check("sw_pulse",      {31'h0, rsp_valid}, 32'h0);
    load_chk("lw_010", 3'b010, 9'h010, 32'hDEADBEEF);

    // SB 0x013
    issue(1'b1, 3'b000, 9'h013, 32'h000000A5);
    check("sb_addr", {23'h0, mem_addr}, 32'h010);
    check("sb_wr",   {28'h0, mem_wr},   32'h8);
    check("sb_wd",   mem_wd,            32'hA5A5A5A5);
    step();
    step();
    load_chk("lb_013",  3'b000, 9'h013, 32'hFFFFFFA5);
    load_chk("lbu_013", 3'b100, 9'h013, 32'h000000A5);
    load_chk("lw_merge", 3'b010, 9'h010, 32'hA5ADBEEF);

    // SH 0x012
    issue(1'b1, 3'b001, 9'h012, 32'h00008001);
    check("sh_wr", {28'h0, mem_wr}, 32'hC);
    check("sh_wd", mem_wd,          32'h80018001);
    step();
    step();
    load_chk("lh_012",  3'b001, 9'h012, 32'hFFFF8001);
    load_chk("lhu_012", 3'b101, 9'h012, 32'h00008001);
    load_chk("lb_011",  3'b000, 9'h011, 32'hFFFFFFBE);

    // Illegal funct3 011 store, unsigned store, 111 load
    issue(1'b1, 3'b011, 9'h020, 32'h12345678);
    check("ill011_vld", {31'h0, rsp_valid}, 32'h1);
    check("ill011_err", {31'h0, rsp_err},   32'h1);
    check("ill011_wr",  {28'h0, mem_wr},    32'h0);
    check("ill011_rd",  rsp_rdata,          32'h0);
    step();
    check("ill011_done", {31'h0, rsp_valid}, 32'h0);
    check("ill011_rdy",  {31'h0, req_ready}, 32'h1);
    issue(1'b1, 3'b100, 9'h020, 32'h12345678);
    check("sbu_err", {31'h0, rsp_err}, 32'h1);
    check("sbu_wr",  {28'h0, mem_wr},  32'h0);
    step();
    issue(1'b0, 3'b111, 9'h020, 32'h0);
    check("ill111_err", {31'h0, rsp_err}, 32'h1);
    step();

    // Reset in ACC1 of a store
    issue(1'b1, 3'b010, 9'h030, 32'h12345678);
    check("rmid_wr_on", {28'h0, mem_wr}, 32'hF);
    rst_n = 1'b0;
    #1;
    check("rmid_wr_off", {28'h0, mem_wr},    32'h0);
    check("rmid_vld",    {31'h0, rsp_valid}, 32'h0);
    check("rmid_ready",  {31'h0, req_ready}, 32'h1);
    step();
    rst_n = 1'b1;
    step();
    check("rmid_novld", {31'h0, rsp_valid}, 32'h0);
    step();
    check("rmid_novld2", {31'h0, rsp_valid}, 32'h0);

    // Back-to-back with req_valid held high
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 9'h010;
    for (int i = 0; i < 9; i++) begin
      ready_pat[8-i] = req_ready;
      vld_pat[8-i]   = rsp_valid;
      step();
    end
    req_valid = 1'b0;
    check("b2b_ready_pat", {23'h0, ready_pat}, 32'h124);
    check("b2b_vld_pat",   {23'h0, vld_pat},   32'h049);
    step();
    step();
    step();

    // Misaligned word load at 0x011
    store(3'b010, 9'h010, 32'h44332211);
    store(3'b010, 9'h014, 32'h88776655);
`ifdef LSU_MISALIGN_SPLIT_EN
    issue(1'b0, 3'b010, 9'h011, 32'h0);
    check("mis_acc1_addr", {23'h0, mem_addr}, 32'h010);
    check("mis_acc1_vld",  {31'h0, rsp_valid}, 32'h0);
    step();
    check("mis_acc2_addr", {23'h0, mem_addr}, 32'h014);
    check("mis_acc2_vld",  {31'h0, rsp_valid}, 32'h0);
    step();
    check("mis_vld",   {31'h0, rsp_valid}, 32'h1);
    check("mis_err",   {31'h0, rsp_err},   32'h0);
    check("mis_rdata", rsp_rdata,          32'h55443322);
    step();
`else
    issue(1'b0, 3'b010, 9'h011, 32'h0);
    check("mis_vld",   {31'h0, rsp_valid}, 32'h1);
    check("mis_err",   {31'h0, rsp_err},   32'h1);
    check("mis_rdata", rsp_rdata,          32'h0);
    step();
    issue(1'b1, 3'b001, 9'h013, 32'h0000BEEF);
    check("mish_err", {31'h0, rsp_err}, 32'h1);
    check("mish_wr",  {28'h0, mem_wr},  32'h0);
    step();
    load_chk("mis_untouched", 3'b010, 9'h010, 32'h44332211);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
